// File: rtl/ifetch_pkg.sv
// Shared types and address-field helpers for the instruction-fetch cache.
package ifetch_pkg;

  // Fetch controller states.
  typedef enum logic {
    LOOKUP = 1'b0,
    REFILL = 1'b1
  } state_e;

  // Value presented on the instruction bus whenever there is no hit.
  localparam logic [31:0] INSTR_NOP = 32'h0000_0000;

  // Word-offset field width inside a line (LINES and WORDS are powers of 2, >= 2).
  function automatic int off_w(input int words);
    return $clog2(words);
  endfunction

  // Line-index field width.
  function automatic int idx_w(input int lines);
    return $clog2(lines);
  endfunction

  // Tag field width: everything above byte, offset and index bits.
  function automatic int tag_w(input int lines, input int words);
    return 32 - 2 - $clog2(words) - $clog2(lines);
  endfunction

endpackage

// File: rtl/ifetch_icache_array.sv
// Tag, valid and data storage for the direct-mapped instruction cache.
// Reads are combinational so the fetch bundle settles within the cycle;
// writes happen one word at a time during a refill.
module icache_array
  import ifetch_pkg::*;
#(
  parameter int LINES = 8,
  parameter int WORDS = 4
) (
  input  logic                                 clk,
  input  logic                                 reset,
  // combinational read port
  input  logic [idx_w(LINES)-1:0]              rd_idx_i,
  input  logic [off_w(WORDS)-1:0]              rd_off_i,
  output logic                                 rd_valid_o,
  output logic [tag_w(LINES, WORDS)-1:0]       rd_tag_o,
  output logic [31:0]                          rd_data_o,
  // synchronous word-write port
  input  logic                                 wr_en_i,
  input  logic [idx_w(LINES)-1:0]              wr_idx_i,
  input  logic [off_w(WORDS)-1:0]              wr_off_i,
  input  logic [31:0]                          wr_data_i,
  // set-valid port (also writes the tag)
  input  logic                                 set_valid_i,
  input  logic [idx_w(LINES)-1:0]              sv_idx_i,
  input  logic [tag_w(LINES, WORDS)-1:0]       sv_tag_i
);

  localparam int OFF_W = off_w(WORDS);
  localparam int IDX_W = idx_w(LINES);
  localparam int TAG_W = tag_w(LINES, WORDS);

  logic [31:0]      data_q [LINES*WORDS];
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [LINES-1:0] valid_vec;

  // Data words are written by the refill engine; contents are not reset.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      data_q[{wr_idx_i, wr_off_i}] <= wr_data_i;
    end
  end

  // Tag is recorded when the line becomes valid; contents are not reset.
  always_ff @(posedge clk) begin
    if (set_valid_i) begin
      tag_q[sv_idx_i] <= sv_tag_i;
    end
  end

  // One valid flop per line, cleared asynchronously so a reset mid-refill
  // leaves no line marked valid.
  genvar gi;
  generate
    for (gi = 0; gi < LINES; gi++) begin : g_valid
      logic v_q;
      // Per-line valid bit: set at end of refill, cleared by reset.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          v_q <= 1'b0;
        end else if (set_valid_i && (sv_idx_i == IDX_W'(gi))) begin
          v_q <= 1'b1;
        end
      end
      assign valid_vec[gi] = v_q;
    end
  endgenerate

  assign rd_valid_o = valid_vec[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_data_o  = data_q[{rd_idx_i, rd_off_i}];

  // Keeps the offset width visible for readers; unused beyond port sizing.
  localparam int ADDR_BITS = IDX_W + OFF_W;
  logic [ADDR_BITS-1:0] unused_rd_addr;
  assign unused_rd_addr = {rd_idx_i, rd_off_i};

endmodule

// File: rtl/ifetch_icache.sv
// Instruction-fetch stage: PC register, direct-mapped I-cache lookup and a
// word-by-word refill engine talking req/ack to main memory.
module ifetch_icache
  import ifetch_pkg::*;
#(
  parameter int          LINES    = 8,
  parameter int          WORDS    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pc_load,
  input  logic [31:0] pc_target,
  output logic [31:0] pc,
  output logic [31:0] instruction,
  output logic [31:0] next_pc,
  output logic        hit,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  localparam int OFF_W = off_w(WORDS);
  localparam int IDX_W = idx_w(LINES);
  localparam int TAG_W = tag_w(LINES, WORDS);
  // Width of a line address: tag plus index.
  localparam int LB_W  = TAG_W + IDX_W;

  state_e            state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic [LB_W-1:0]   line_q, line_d;   // line being refilled (tag,index)
  logic [OFF_W-1:0]  cnt_q, cnt_d;     // next word of the line to request

  // Address fields of the current PC.
  logic [OFF_W-1:0]  pc_off;
  logic [IDX_W-1:0]  pc_idx;
  logic [TAG_W-1:0]  pc_tag;

  // Fields of the line under refill.
  logic [IDX_W-1:0]  ref_idx;
  logic [TAG_W-1:0]  ref_tag;

  logic              rd_valid;
  logic [TAG_W-1:0]  rd_tag;
  logic [31:0]       rd_data;

  logic              lookup_hit;
  logic              last_word;
  logic              wr_en;
  logic              set_valid;

  assign pc_off  = pc_q[2 +: OFF_W];
  assign pc_idx  = pc_q[2 + OFF_W +: IDX_W];
  assign pc_tag  = pc_q[2 + OFF_W + IDX_W +: TAG_W];

  assign ref_idx = line_q[0 +: IDX_W];
  assign ref_tag = line_q[IDX_W +: TAG_W];

  icache_array #(
    .LINES (LINES),
    .WORDS (WORDS)
  ) u_array (
    .clk         (clk),
    .reset       (reset),
    .rd_idx_i    (pc_idx),
    .rd_off_i    (pc_off),
    .rd_valid_o  (rd_valid),
    .rd_tag_o    (rd_tag),
    .rd_data_o   (rd_data),
    .wr_en_i     (wr_en),
    .wr_idx_i    (ref_idx),
    .wr_off_i    (cnt_q),
    .wr_data_i   (mem_rdata),
    .set_valid_i (set_valid),
    .sv_idx_i    (ref_idx),
    .sv_tag_i    (ref_tag)
  );

  // A hit is only reported while looking up; refill cycles never hit even
  // if the array already holds a matching line.
  assign lookup_hit  = (state_q == LOOKUP) && rd_valid && (rd_tag == pc_tag);
  assign last_word   = (cnt_q == OFF_W'(WORDS - 1));

  // Refill writes: each acknowledged word lands in the latched line; the
  // final word also publishes the tag and valid bit.
  assign wr_en       = (state_q == REFILL) && mem_ack;
  assign set_valid   = wr_en && last_word;

  // Fetch bundle and memory request are pure functions of registered state,
  // so they settle shortly after posedge and hold until the next one.
  assign pc          = pc_q;
  assign hit         = lookup_hit;
  assign instruction = lookup_hit ? rd_data : INSTR_NOP;
  assign next_pc     = pc_q + 32'd4;
  assign mem_req     = (state_q == REFILL);
  assign mem_addr    = {line_q, cnt_q, 2'b00};

  // State, PC, refill line and counter registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= LOOKUP;
      pc_q    <= RESET_PC;
      line_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      line_q  <= line_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: redirect beats sequential advance; a miss latches the
  // line base and starts a refill; a redirect during refill updates the PC
  // but lets the in-flight line finish.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    line_d  = line_q;
    cnt_d   = cnt_q;
    case (state_q)
      LOOKUP: begin
        if (pc_load) begin
          pc_d = pc_target;
        end else if (lookup_hit) begin
          pc_d = pc_q + 32'd4;
        end else begin
          line_d  = pc_q[31 -: LB_W];
          cnt_d   = '0;
          state_d = REFILL;
        end
      end
      REFILL: begin
        if (mem_ack) begin
          cnt_d = cnt_q + OFF_W'(1);
          if (last_word) begin
            state_d = LOOKUP;
          end
        end
        if (pc_load) begin
          pc_d = pc_target;
        end
      end
      default: begin
        state_d = LOOKUP;
      end
    endcase
  end

endmodule
